// File: rtl/carregador_instrucao.sv
// Instruction RAM loader: assembles a byte stream (MSB first) into 32-bit words and writes
// them from address 0 until a HALT word or a full RAM. Optional CHECKSUM_EN adds a trailing sum byte.
module carregador_instrucao #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DEPTH   = 512,
  parameter logic [4:0]  HALT_OP = 5'd21
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              START,
  input  logic              BYTE_VALID,
  input  logic [7:0]        BYTE_DATA,
  output logic              BYTE_READY,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [31:0]       WR_DATA,
  output logic [ADDR_W-1:0] WORD_COUNT,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERRO,
  output logic              CPU_HOLD
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_FIM   = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;
`ifdef CHECKSUM_EN
  localparam logic [2:0] S_CHK   = 3'd5;
  logic [7:0]  r_sum;
`endif

  logic [2:0]        r_state;
  logic [1:0]        r_idx;
  logic [23:0]       r_asm;
  logic              r_ready;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic [ADDR_W-1:0] r_count;
  logic              r_busy;
  logic              r_done;
  logic              r_erro;
  logic              w_xfer;

  assign w_xfer = BYTE_VALID && r_ready;

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      r_state   <= S_IDLE;
      r_idx     <= 2'd0;
      r_asm     <= 24'd0;
      r_ready   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= 32'd0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_erro    <= 1'b0;
`ifdef CHECKSUM_EN
      r_sum     <= 8'd0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE, S_FIM, S_ERR: begin
          if (START) begin
            r_state   <= S_RECV;
            r_wr_addr <= '0;
            r_count   <= '0;
            r_idx     <= 2'd0;
            r_done    <= 1'b0;
            r_erro    <= 1'b0;
            r_busy    <= 1'b1;
            r_ready   <= 1'b1;
`ifdef CHECKSUM_EN
            r_sum     <= 8'd0;
`endif
          end
        end
        S_RECV: begin
          if (w_xfer) begin
            r_idx <= r_idx + 2'd1;
`ifdef CHECKSUM_EN
            r_sum <= r_sum + BYTE_DATA;
`endif
            case (r_idx)
              2'd0: r_asm[23:16] <= BYTE_DATA;
              2'd1: r_asm[15:8]  <= BYTE_DATA;
              2'd2: r_asm[7:0]   <= BYTE_DATA;
              default: begin
                // Fourth byte goes straight into the output word; WR_EN follows next cycle.
                r_wr_data <= {r_asm, BYTE_DATA};
                r_wr_en   <= 1'b1;
                r_ready   <= 1'b0;
                r_state   <= S_WRITE;
              end
            endcase
          end
        end
        S_WRITE: begin
          r_count <= r_count + ADDR_W'(1);
          if (r_wr_data[31:27] == HALT_OP) begin
`ifdef CHECKSUM_EN
            r_state <= S_CHK;
            r_ready <= 1'b1;
`else
            r_state <= S_FIM;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
`endif
          end else if (r_wr_addr == ADDR_W'(DEPTH - 1)) begin
            r_state <= S_ERR;
            r_busy  <= 1'b0;
            r_erro  <= 1'b1;
          end else begin
            r_wr_addr <= r_wr_addr + ADDR_W'(1);
            r_ready   <= 1'b1;
            r_state   <= S_RECV;
          end
        end
`ifdef CHECKSUM_EN
        S_CHK: begin
          if (w_xfer) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            if (BYTE_DATA == r_sum) begin
              r_state <= S_FIM;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_ERR;
              r_erro  <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign BYTE_READY = r_ready;
  assign WR_EN      = r_wr_en;
  assign WR_ADDR    = r_wr_addr;
  assign WR_DATA    = r_wr_data;
  assign WORD_COUNT = r_count;
  assign BUSY       = r_busy;
  assign DONE       = r_done;
  assign ERRO       = r_erro;
  assign CPU_HOLD   = r_busy;

endmodule

// File: tb/tb_carregador_instrucao.sv
// Scoreboard bench for carregador_instrucao: stimulus pushes expected RAM writes,
// a negedge monitor pops and compares every WR_EN pulse.
module tb_carregador_instrucao;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b0;
  logic        START = 1'b0;
  logic        BYTE_VALID = 1'b0;
  logic [7:0]  BYTE_DATA = 8'd0;
  logic        BYTE_READY;
  logic        WR_EN;
  logic [11:0] WR_ADDR;
  logic [31:0] WR_DATA;
  logic [11:0] WORD_COUNT;
  logic        BUSY;
  logic        DONE;
  logic        ERRO;
  logic        CPU_HOLD;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [11:0] exp_addr;
  logic [7:0]  tb_sum;

  carregador_instrucao dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
    .START      (START),
    .BYTE_VALID (BYTE_VALID),
    .BYTE_DATA  (BYTE_DATA),
    .BYTE_READY (BYTE_READY),
    .WR_EN      (WR_EN),
    .WR_ADDR    (WR_ADDR),
    .WR_DATA    (WR_DATA),
    .WORD_COUNT (WORD_COUNT),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERRO       (ERRO),
    .CPU_HOLD   (CPU_HOLD)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #900000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the oldest expected write, with BYTE_READY low.
  always @(negedge CLOCK) begin
    if (WR_EN === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr %h data %h want no write", WR_ADDR, WR_DATA);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_addr", 32'(WR_ADDR), 32'(e.addr));
        check("wr_data", WR_DATA, e.data);
      end
      check("ready_low_in_write", 32'(BYTE_READY), 32'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    if (gap > 0) begin
      BYTE_VALID = 1'b0;
      repeat (gap) @(posedge CLOCK);
      #1;
    end
    BYTE_VALID = 1'b1;
    BYTE_DATA  = b;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLOCK);
      got = BYTE_READY;
      @(posedge CLOCK);
    end
    #1;
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL byte_accept: got not accepted want accepted for byte %h", b);
    end
    tb_sum = tb_sum + b;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    exp_t e;
    e.addr = exp_addr;
    e.data = w;
    sb.push_back(e);
    exp_addr = exp_addr + 12'd1;
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(posedge CLOCK);
    #1;
    START    = 1'b0;
    exp_addr = 12'd0;
    tb_sum   = 8'd0;
  endtask

  task automatic send_checksum(input logic [7:0] delta, input int gap);
`ifdef CHECKSUM_EN
    logic [7:0] s;
    s = tb_sum + delta;
    send_byte(s, gap);
`else
    if (delta != 8'd0) $display("checksum byte skipped: feature not built");
`endif
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(negedge CLOCK);
      idle = !BUSY;
    end
    if (!idle) begin
      n_vec++;
      n_err++;
      $display("FAIL load_end: got BUSY=1 want BUSY=0 within 40 cycles");
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, 32'(BYTE_READY), 32'd0);
    check({tag, "_wr_en"}, 32'(WR_EN), 32'd0);
    check({tag, "_wr_addr"}, 32'(WR_ADDR), 32'd0);
    check({tag, "_wr_data"}, WR_DATA, 32'd0);
    check({tag, "_count"}, 32'(WORD_COUNT), 32'd0);
    check({tag, "_busy"}, 32'(BUSY), 32'd0);
    check({tag, "_done"}, 32'(DONE), 32'd0);
    check({tag, "_erro"}, 32'(ERRO), 32'd0);
    check({tag, "_hold"}, 32'(CPU_HOLD), 32'd0);
  endtask

  task automatic check_end(input string tag, input logic done, input logic erro,
                           input logic [11:0] cnt);
    check({tag, "_done"}, 32'(DONE), 32'(done));
    check({tag, "_erro"}, 32'(ERRO), 32'(erro));
    check({tag, "_count"}, 32'(WORD_COUNT), 32'(cnt));
    check({tag, "_busy"}, 32'(BUSY), 32'd0);
    check({tag, "_hold"}, 32'(CPU_HOLD), 32'd0);
    check({tag, "_pending"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    exp_addr = 12'd0;
    tb_sum   = 8'd0;
    // Reset
    @(posedge CLOCK);
    @(posedge CLOCK);
    @(negedge CLOCK);
    check_zero("reset");
    RESET = 1'b1;
    @(posedge CLOCK);
    #1;

    // 1. Basic load, plus WR_EN latency after the fourth byte
    pulse_start();
    send_word(32'hB800_0000, 0);
    @(negedge CLOCK);
    check("wr_latency", 32'(WR_EN), 32'd1);
    send_word(32'hA800_0000, 0);
    send_checksum(8'd0, 0);
    BYTE_VALID = 1'b0;
    wait_idle();
    check_end("basic", 1'b1, 1'b0, 12'd2);

    // 2. Backpressure: three idle cycles before every byte
    pulse_start();
    send_word(32'hB800_0000, 3);
    send_word(32'hA800_0000, 3);
    send_checksum(8'd0, 3);
    BYTE_VALID = 1'b0;
    wait_idle();
    check_end("backpressure", 1'b1, 1'b0, 12'd2);

    // 3. Overflow: 512 non-halt words fill the RAM
    pulse_start();
    for (int w = 0; w < 512; w++) send_word(32'hB800_0000, 0);
    BYTE_VALID = 1'b0;
    wait_idle();
    check_end("overflow", 1'b0, 1'b1, 12'h200);

    // 4. Reset mid-load discards the partial word
    pulse_start();
    send_byte(8'hB8, 0);
    send_byte(8'h00, 0);
    BYTE_VALID = 1'b0;
    RESET      = 1'b0;
    @(posedge CLOCK);
    @(negedge CLOCK);
    check_zero("midreset");
    RESET = 1'b1;
    @(posedge CLOCK);
    #1;
    pulse_start();
    send_word(32'hB800_0000, 0);
    send_word(32'hA800_0000, 0);
    send_checksum(8'd0, 0);
    BYTE_VALID = 1'b0;
    wait_idle();
    check_end("after_reset", 1'b1, 1'b0, 12'd2);

    // 5. START while busy is ignored
    pulse_start();
    sb.push_back('{addr: 12'd0, data: 32'hB800_0000});
    sb.push_back('{addr: 12'd1, data: 32'hA800_0000});
    send_byte(8'hB8, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'hA8, 0);
    BYTE_VALID = 1'b0;
    START      = 1'b1;
    @(posedge CLOCK);
    #1;
    START = 1'b0;
    check("start_busy_hold", 32'(CPU_HOLD), 32'd1);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_checksum(8'd0, 0);
    BYTE_VALID = 1'b0;
    wait_idle();
    check_end("start_busy", 1'b1, 1'b0, 12'd2);

`ifdef CHECKSUM_EN
    // 6. Wrong checksum byte (0x61 instead of 0x60) aborts after both writes
    pulse_start();
    send_word(32'hB800_0000, 0);
    send_word(32'hA800_0000, 0);
    check("chk_sum_model", 32'(tb_sum), 32'h60);
    send_checksum(8'd1, 0);
    BYTE_VALID = 1'b0;
    wait_idle();
    check_end("chk_bad", 1'b0, 1'b1, 12'd2);
`endif

    repeat (3) @(posedge CLOCK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
